// File: rtl/bcd_timer_ctrl.sv
// rtl/bcd_timer_ctrl.sv - four-digit BCD up-counter with prescaler, start/stop/load/clear control and terminal limit
module bcd_timer_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Clear,
  input  logic        Load,
  input  logic [15:0] Preset,
  input  logic [15:0] Limit,
  output logic [15:0] Cuenta,
  output logic        Tick,
  output logic        Running,
  output logic        Done
);

  localparam int              PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PS_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [15:0]   count_next;
  logic [15:0]   preset_sat;
  logic          tick_now;
  logic          limit_hit;
  logic          stop_cmd;
  logic          start_cmd;

  // Decimal ripple increment: a digit advances only while every lower digit rolled over from 9.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        if (v[4*k +: 4] >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Tick, next count, limit match, saturated preset and the effective Stop/Start after priority masking.
  always_comb begin
    tick_now   = (state == S_RUN) && (presc == PS_LAST);
    count_next = bcd_inc(Cuenta);
    // A limit digit above 9 can never equal a legal BCD count, so no separate validity check is needed.
    limit_hit  = (Limit != 16'h0000) && (count_next == Limit);
    preset_sat = '0;
    for (int k = 0; k < 4; k++) begin
      preset_sat[4*k +: 4] = (Preset[4*k +: 4] > 4'd9) ? 4'd9 : Preset[4*k +: 4];
    end
    // Load masks Stop/Start even in RUN, where Load itself has no effect.
    stop_cmd  = !Clear && !Load && Stop;
    start_cmd = !Clear && !Load && !Stop && Start;
  end

  assign Tick    = tick_now;
  assign Running = (state == S_RUN);
  assign Done    = (state == S_DONE);

  // State, prescaler and count update with Clear > Load > Stop > Start priority.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state  <= S_IDLE;
      presc  <= '0;
      Cuenta <= '0;
    end else if (Clear) begin
      state  <= S_IDLE;
      presc  <= '0;
      Cuenta <= '0;
    end else if (Load && (state != S_RUN)) begin
      state  <= S_IDLE;
      presc  <= '0;
      Cuenta <= preset_sat;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_cmd) begin
            state <= S_RUN;
            presc <= '0;
          end
        end
        S_PAUSE: begin
          if (start_cmd) state <= S_RUN;
        end
        S_RUN: begin
          if (tick_now) begin
            // The increment on a tick always completes, even if Stop lands in the same cycle.
            Cuenta <= count_next;
            presc  <= '0;
            if (limit_hit)     state <= S_DONE;
            else if (stop_cmd) state <= S_PAUSE;
          end else if (stop_cmd) begin
            state <= S_PAUSE;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
